// File: rtl/gcd_ctrl.sv
// GCD sequencer driving the shared 32-bit ALU by repeated subtraction.
// Optional GCD_ITER_CNT_EN adds a saturating 16-bit iter_cnt output.
module gcd_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_cin,
  input  logic [31:0]      alu_d
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [15:0]      iter_cnt
`endif
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_NE  = 4'b1111;
  localparam logic [3:0] OP_LT  = 4'b1110;
  localparam logic [3:0] OP_ADC = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_NE,
    S_LT,
    S_SUB,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] alu_res;

  assign alu_res = alu_d[WIDTH-1:0];

`ifdef GCD_ITER_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign iter_cnt = cnt_q;
`endif

  // NOTE: every variable gets a default at the top of the block so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    lt_d    = lt_q;
`ifdef GCD_ITER_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ra_d    = in_a;
          rb_d    = in_b;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
`ifdef GCD_ITER_CNT_EN
        cnt_d = '0;
`endif
        if (ra_q == '0) begin
          ra_d    = rb_q;
          state_d = S_DONE;
        end else if (rb_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_NE;
        end
      end
      S_NE:  state_d = alu_d[0] ? S_LT : S_DONE;
      S_LT: begin
        lt_d    = alu_d[0];
        state_d = S_SUB;
      end
      S_SUB: begin
        // The smaller operand is subtracted from the larger one.
        if (lt_q) rb_d = alu_res;
        else      ra_d = alu_res;
`ifdef GCD_ITER_CNT_EN
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
        state_d = S_NE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      lt_q    <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      lt_q    <= lt_d;
`ifdef GCD_ITER_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs decode from flops only, so reset reaches them immediately.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_gcd   = (state_q == S_DONE) ? ra_q : '0;
    alu_s     = OP_NOP;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    unique case (state_q)
      S_NE: begin
        alu_s = OP_NE;
        alu_a = 32'(ra_q);
        alu_b = 32'(rb_q);
      end
      S_LT: begin
        alu_s = OP_LT;
        alu_a = 32'(ra_q);
        alu_b = 32'(rb_q);
      end
      S_SUB: begin
        alu_s   = OP_ADC;
        alu_cin = 1'b1;
        if (lt_q) begin
          alu_a = 32'(rb_q);
          alu_b = 32'(~ra_q);
        end else begin
          alu_a = 32'(ra_q);
          alu_b = 32'(~rb_q);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl with a behavioural ALU and an expected-result queue.
module tb_gcd_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [31:0]      alu_a, alu_b, alu_d;
  logic [3:0]       alu_s;
  logic             alu_cin;
`ifdef GCD_ITER_CNT_EN
  logic [15:0]      iter_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] g;
    int          k;
    int          lat;
    bit          zero;
  } exp_t;

  exp_t sb[$];

  gcd_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_d(alu_d)
`ifdef GCD_ITER_CNT_EN
    , .iter_cnt(iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU covering the opcodes the controller may issue.
  always_comb begin
    alu_d = '0;
    case (alu_s)
      4'b1111: alu_d = {31'b0, alu_a != alu_b};
      4'b1110: alu_d = {31'b0, alu_a < alu_b};
      4'b0001: alu_d = alu_a + alu_b + {31'b0, alu_cin};
      default: alu_d = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] x, y;
    e.k = 0;
    e.zero = (a == 0) || (b == 0);
    if (a == 0) begin
      e.g = b; e.lat = 2;
    end else if (b == 0) begin
      e.g = a; e.lat = 2;
    end else begin
      x = a; y = b;
      while (x != y) begin
        if (x < y) y = y - x;
        else       x = x - y;
        e.k++;
      end
      e.g = x;
      e.lat = 3 * e.k + 3;
    end
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_gcd"},   32'(out_gcd), 32'd0);
    check({tag, "_alu_a"},     alu_a, 32'd0);
    check({tag, "_alu_b"},     alu_b, 32'd0);
    check({tag, "_alu_s"},     32'(alu_s), 32'd0);
    check({tag, "_alu_cin"},   32'(alu_cin), 32'd0);
`ifdef GCD_ITER_CNT_EN
    check({tag, "_iter_cnt"},  32'(iter_cnt), 32'd0);
`endif
  endtask

  // Handshake in cycle 0; returns just after the edge that starts cycle 1.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   cyc = 1;
    int   subs = 0;
    int   cin_bad = 0;
    bit   nonzero = 0;
    bit   seen = 0;
    for (int guard = 0; guard < 300; guard++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (alu_s != 4'b0000) nonzero = 1;
      if (alu_s == 4'b0001) subs++;
      if (alu_cin != (alu_s == 4'b0001) || alu_s == 4'b0010) cin_bad++;
      @(posedge clk);
      cyc++;
    end
    check({tag, "_out_valid_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_gcd"},     out_gcd, e.g);
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_subs"},    32'(subs), 32'(e.k));
    check({tag, "_cin_op"},  32'(cin_bad), 32'd0);
    check({tag, "_alu_used"}, 32'(nonzero), 32'(!e.zero));
`ifdef GCD_ITER_CNT_EN
    check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(e.k));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        in_a = 32'd5; in_b = 32'd3; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, "_hold_gcd"},   out_gcd, e.g);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ret_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_ret_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ret_out_gcd"},   32'(out_gcd), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    #13 rst_n = 1'b1;

    send(32'd12, 32'd8);  collect("g12_8", 0);
    send(32'd35, 32'd14); collect("g35_14", 0);
    send(32'd17, 32'd17); collect("g17_17", 0);
    send(32'd0, 32'd7);   collect("g0_7", 0);
    send(32'd9, 32'd0);   collect("g9_0", 0);
    send(32'd0, 32'd0);   collect("g0_0", 0);
    send(32'd1, 32'd5);   collect("g1_5", 0);
    send(32'd48, 32'd180); collect("g48_180", 0);

    // The pulse of in_valid during the hold must not start a new operation.
    send(32'd12, 32'd8);  collect("bp", 5);
    @(negedge clk);
    check("bp_ignored_valid", 32'(out_valid), 32'd0);
    check("bp_ignored_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in cycle 4 (SUB) of an operation.
    send(32'd12, 32'd8);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd6, 32'd4);   collect("after_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Sequencing controller that computes the greatest common divisor of two unsigned operands by repeated subtraction on the shared 32-bit ALU. The controller drives the ALU operand, opcode and carry-in ports, captures the ALU result each cycle, and exposes a valid/ready handshake on both its operand input and its result output. It sits between the GCD request source and the ALU, and is the only master of the ALU while the GCD unit is in use.

## Interface
- WIDTH, 32, operand/result width (1..32); values are zero-extended onto the 32-bit ALU ports and `alu_d` is truncated back to WIDTH.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands (IDLE only).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid (DONE only).
- out_ready  in  1  consumer accepts the result.
- out_gcd  out  WIDTH  GCD result.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_s  out  4  ALU opcode.
- alu_cin  out  1  ALU carry-in.
- alu_d  in  32  ALU result (combinational from `alu_a`/`alu_b`/`alu_s`).

## Operation
- Internal registers: `ra`, `rb` (WIDTH), `lt` (1), and the state register.
- Opcodes used: 4'b0000 no-op, 4'b1111 not-equal, 4'b1110 less-than, 4'b0001 add with carry.
- Subtraction is performed as X + ~Y + 1, using opcode 0001 with `alu_cin=1`. Opcode 0010 is never issued.
- ALU ports are pure functions of the state and registers. In any state not listed below: `alu_s=0000`, `alu_a=alu_b=0`, `alu_cin=0`.
- States and transitions:
  - IDLE: `in_ready=1`. On `in_valid`, load `ra<=in_a`, `rb<=in_b`, then go to CHK.
  - CHK (no ALU use): if `ra==0`, set `ra<=rb` and go to DONE. Otherwise, if `rb==0`, go to DONE. Otherwise go to NE.
  - NE: `alu_s=1111`, `alu_a=ra`, `alu_b=rb`. If `alu_d[0]==0`, go to DONE (result is `ra`). Otherwise go to LT.
  - LT: `alu_s=1110`, `alu_a=ra`, `alu_b=rb`. Set `lt<=alu_d[0]`, then go to SUB.
  - SUB: `alu_s=0001`, `alu_cin=1`.
    - If `lt`: `alu_a=rb`, `alu_b=~ra`, `rb<=alu_d`.
    - Otherwise: `alu_a=ra`, `alu_b=~rb`, `ra<=alu_d`.
    - Then go to NE.
  - DONE: `out_valid=1`, `out_gcd=ra`. On `out_ready`, go to IDLE.
- Zero operands: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
- `in_valid` outside IDLE is ignored; the operands are not captured.
- `out_gcd` is held stable for the entire time `out_valid=1`. `out_gcd` is 0 outside DONE.
- Reset, whether in idle or mid-operation, forces IDLE and clears all registers; the in-flight operation is discarded.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_gcd=0`, `alu_a=0`, `alu_b=0`, `alu_s=0000`, `alu_cin=0`.
- Cycle numbering: the handshake cycle (`in_valid & in_ready`) is cycle 0.
- CHK occurs in cycle 1.
- Zero-operand case: `out_valid` rises in cycle 2.
- Otherwise each subtraction costs 3 cycles (NE, LT, SUB). With k subtractions, `out_valid` first rises in cycle 3k+3.
- Completion: DONE followed by `out_ready=1` returns to IDLE on the next edge. `in_ready` is high in the following cycle, so the minimum gap between transactions is 1 cycle.
- No bound on iteration count. The worst case is about 3·2^WIDTH cycles, e.g. gcd(1, max).

## Configuration
- `GCD_ITER_CNT_EN` defined:
  - Adds output port `iter_cnt  out  16`, the number of SUB cycles in the current operation.
  - Cleared in CHK, incremented in SUB, saturates at 16'hFFFF.
  - Valid and stable while `out_valid=1`; reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- a=12, b=8 -> `out_gcd=4`, `out_valid` rises in cycle 9, `iter_cnt=2`. ALU trace shows opcodes 1111, 1110, 0001 repeated, with `alu_cin=1` only in SUB.
- a=35, b=14 -> `out_gcd=7` in cycle 12, `iter_cnt=3`. a=17, b=17 -> `out_gcd=17` in cycle 3, `iter_cnt=0`.
- a=0, b=7 -> `out_gcd=7` in cycle 2. a=9, b=0 -> `out_gcd=9`. a=0, b=0 -> `out_gcd=0`. The ALU stays at opcode 0000 throughout.
- Backpressure: a=12, b=8 with `out_ready` held low for 5 cycles after `out_valid`. `out_gcd` stays 4, `in_ready` stays 0, and a new `in_valid` pulse is ignored. With `out_ready=1`, `in_ready` is high one cycle later.
- `rst_n` asserted in cycle 4 of a=12, b=8. All outputs take their reset values immediately, without waiting for a clock edge. After release, a new request a=6, b=4 returns 2 in cycle 9.
